// File: rtl/memory_pkg.sv
// memory_pkg: grid constants, game FSM states and the card-value mapping for the memory game
package memory_pkg;
    localparam int NUM_CARDS = 16;
    localparam int GRID_COLS = 4;
    typedef enum logic [2:0] {PICK1, PICK2, COMPARE, HOLD, DONE} state_t;
    function automatic logic [2:0] card_value(input logic [3:0] pos);
        return 3'(pos % 4'd8);
    endfunction
endpackage

// File: rtl/hold_timer.sv
// hold_timer: down-counter that keeps a mismatched pair face-up for HOLD_CYCLES cycles
module hold_timer #(
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);
    localparam int W = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    logic [W-1:0] count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (load) count <= W'(HOLD_CYCLES - 1);
        else if (count != '0) count <= count - W'(1);
    end
    assign expire = count == '0;
endmodule

// File: rtl/memory_game_ctrl.sv
// memory_game_ctrl: cursor navigation, pick/compare FSM and scoring for a 4x4 memory card game
module memory_game_ctrl
    import memory_pkg::*;
#(
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 btn_sel,
    output logic [3:0]           cursor,
    output logic [NUM_CARDS-1:0] face_up,
    output logic [NUM_CARDS-1:0] matched,
    output logic [7:0]           moves,
    output logic                 game_done
);
    localparam int CW = $clog2(GRID_COLS);
    state_t               state;
    logic [3:0]           first_pick, second_pick, cursor_nxt;
    logic [CW-1:0]        col;
    logic [3-CW:0]        row;
    logic [NUM_CARDS-1:0] cur_bit, pair_bits;
    logic                 is_match, all_matched, expire;
    assign row = cursor[3:CW];
    assign col = cursor[CW-1:0];
    // row/col arithmetic wraps naturally at the grid edge
    assign cursor_nxt = btn_up    ? {row - 1'b1, col} :
                        btn_down  ? {row + 1'b1, col} :
                        btn_left  ? {row, col - 1'b1} :
                        btn_right ? {row, col + 1'b1} : cursor;
    assign cur_bit     = NUM_CARDS'(1) << cursor;
    assign pair_bits   = (NUM_CARDS'(1) << first_pick) | (NUM_CARDS'(1) << second_pick);
    assign is_match    = card_value(first_pick) == card_value(second_pick);
    assign all_matched = &(matched | pair_bits);
    hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state == COMPARE && !is_match),
        .expire(expire)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PICK1;
            cursor      <= '0;
            face_up     <= '0;
            matched     <= '0;
            moves       <= '0;
            game_done   <= 1'b0;
            first_pick  <= '0;
            second_pick <= '0;
        end else begin
            if (state != DONE) cursor <= cursor_nxt;
            case (state)
                PICK1: if (btn_sel && !face_up[cursor]) begin
                    first_pick <= cursor;
                    face_up    <= face_up | cur_bit;
                    state      <= PICK2;
                end
                PICK2: if (btn_sel && !face_up[cursor]) begin
                    second_pick <= cursor;
                    face_up     <= face_up | cur_bit;
                    state       <= COMPARE;
                end
                COMPARE: begin
                    moves <= moves + 8'(moves != 8'hFF);
                    if (is_match) begin
                        matched   <= matched | pair_bits;
                        game_done <= all_matched;
                        state     <= all_matched ? DONE : PICK1;
                    end else state <= HOLD;
                end
                HOLD: if (expire) begin
                    face_up <= matched;
                    state   <= PICK1;
                end
                DONE: if (btn_sel) begin
                    cursor    <= '0;
                    face_up   <= '0;
                    matched   <= '0;
                    moves     <= '0;
                    game_done <= 1'b0;
                    state     <= PICK1;
                end
                default: state <= PICK1;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_game_ctrl.sv
// tb_memory_game_ctrl: directed stimulus for memory_game_ctrl with hand-computed expectations
module tb_memory_game_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
    logic [3:0]  cursor;
    logic [15:0] face_up, matched;
    logic [7:0]  moves;
    logic        game_done;
    int          checks = 0, errors = 0, cur = 0, mv = 0;
    logic [15:0] m = '0;
    int          pairs [6] = '{0, 1, 2, 4, 6, 7};

    memory_game_ctrl #(.HOLD_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel), .cursor(cursor), .face_up(face_up),
        .matched(matched), .moves(moves), .game_done(game_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic u, input logic d, input logic l, input logic r, input logic s);
        @(negedge clk);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_sel = s;
        @(posedge clk);
        #1;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_sel = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic sel();
        press(0, 0, 0, 0, 1);
    endtask

    task automatic goto(input int t);
        while (cur % 4 != t % 4) begin press(0, 0, 0, 1, 0); cur = (cur / 4) * 4 + (cur + 1) % 4; end
        while (cur / 4 != t / 4) begin press(0, 1, 0, 0, 0); cur = (cur + 4) % 16; end
        chk("goto_cursor", 16'(cursor), 16'(t));
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_cursor"}, 16'(cursor), 16'h0);
        chk({tag, "_face_up"}, face_up, 16'h0);
        chk({tag, "_matched"}, matched, 16'h0);
        chk({tag, "_moves"}, 16'(moves), 16'h0);
        chk({tag, "_done"}, 16'(game_done), 16'h0);
    endtask

    initial begin
        #12;
        all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1; btn_left = 1'b1;
        @(posedge clk);
        #1 btn_left = 1'b0;
        cur = 3;
        chk("left_wrap", 16'(cursor), 16'd3);
        press(1, 0, 0, 0, 0);
        cur = 15;
        chk("up_wrap", 16'(cursor), 16'd15);
        press(1, 1, 1, 1, 0);
        cur = 11;
        chk("priority_up", 16'(cursor), 16'd11);
        goto(1);
        sel();
        chk("pick1_face", face_up, 16'h0002);
        goto(2);
        sel();
        chk("pick2_face", face_up, 16'h0006);
        chk("pick2_moves", 16'(moves), 16'd0);
        idle(1);
        chk("mis_face", face_up, 16'h0006);
        chk("mis_moves", 16'(moves), 16'd1);
        chk("mis_matched", matched, 16'h0);
        press(0, 0, 0, 1, 0);
        cur = 3;
        chk("hold_move", 16'(cursor), 16'd3);
        sel();
        chk("hold_sel_ignored", face_up, 16'h0006);
        idle(1);
        chk("hold_last", face_up, 16'h0006);
        idle(1);
        chk("hold_expired", face_up, 16'h0000);
        press(0, 1, 0, 0, 1);
        cur = 7;
        chk("sel_premove_face", face_up, 16'h0008);
        chk("sel_premove_cursor", 16'(cursor), 16'd7);
        goto(11);
        sel();
        chk("pair3_face", face_up, 16'h0808);
        idle(1);
        chk("pair3_matched", matched, 16'h0808);
        chk("pair3_moves", 16'(moves), 16'd2);
        sel();
        chk("sel_matched_ignored", face_up, 16'h0808);
        goto(5);
        sel();
        chk("sel5_face", face_up, 16'h0828);
        sel();
        chk("sel5_twice", face_up, 16'h0828);
        goto(13);
        sel();
        chk("pair5_face", face_up, 16'h2828);
        idle(1);
        chk("pair5_matched", matched, 16'h2828);
        chk("pair5_moves", 16'(moves), 16'd3);
        m = 16'h2828;
        mv = 3;
        foreach (pairs[k]) begin
            goto(pairs[k]);
            sel();
            goto(pairs[k] + 8);
            sel();
            chk("pre_cmp_done", 16'(game_done), 16'd0);
            idle(1);
            m = m | (16'h0101 << pairs[k]);
            mv++;
            chk("loop_matched", matched, m);
            chk("loop_moves", 16'(moves), 16'(mv));
        end
        chk("done_flag", 16'(game_done), 16'd1);
        chk("done_matched", matched, 16'hFFFF);
        chk("done_face", face_up, 16'hFFFF);
        chk("done_moves", 16'(moves), 16'd9);
        press(0, 0, 1, 0, 0);
        chk("done_move_ignored", 16'(cursor), 16'd15);
        chk("done_still", 16'(game_done), 16'd1);
        sel();
        cur = 0;
        all_zero("restart");
        goto(1);
        sel();
        goto(2);
        sel();
        idle(2);
        chk("hold2_face", face_up, 16'h0006);
        chk("hold2_moves", 16'(moves), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1; btn_sel = 1'b1;
        @(posedge clk);
        #1 btn_sel = 1'b0;
        cur = 0;
        chk("fresh_pick", face_up, 16'h0001);
        idle(6);
        chk("no_stale_hold", face_up, 16'h0001);
        chk("no_stale_moves", 16'(moves), 16'd0);
        goto(8);
        sel();
        idle(1);
        chk("fresh_matched", matched, 16'h0101);
        chk("fresh_face", face_up, 16'h0101);
        chk("fresh_moves", 16'(moves), 16'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_game_ctrl.md
MEMORY_GAME_CTRL -- requirements
Module: memory_game_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: HOLD_CYCLES, default 25_000_000, is the number of cycles a mismatched pair stays face-up.
REQ-003 clk  input  1  system clock, 25 MHz pixel clock domain.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 btn_up, btn_down, btn_left, btn_right  input  1 each  single-cycle debounced move pulses.
REQ-006 btn_sel  input  1  single-cycle debounced select pulse.
REQ-007 cursor  output  4  selected grid position (row = cursor[3:2], col = cursor[1:0]); same encoding as the renderer pos input.
REQ-008 face_up  output  16  bit i drives the enable of card renderer instance i.
REQ-009 matched  output  16  bit i set once card i is paired.
REQ-010 moves  output  8  completed pair attempts, saturating at 255.
REQ-011 game_done  output  1  high while all 16 cards are matched.

Function
REQ-012 All outputs SHALL be registered and updated one cycle after the causing input pulse.
REQ-013 Card value of position i SHALL be i mod 8, so pairs are (i, i+8).
REQ-014 face_up SHALL equal matched OR first_pick bit OR second_pick bit.
REQ-015 FSM states: PICK1, PICK2, COMPARE, HOLD, DONE.
REQ-016 PICK1 + btn_sel on a card that is neither face-up nor matched: record first_pick = cursor, go to PICK2.
REQ-017 PICK2 + btn_sel on a card that is not face-up: record second_pick = cursor, go to COMPARE.
REQ-018 btn_sel on a face-up or matched card SHALL be ignored with no state change.
REQ-019 COMPARE SHALL last exactly one cycle and increment moves (saturating).
REQ-020 COMPARE with equal values: set both matched bits; go to DONE if all 16 are matched, else to PICK1.
REQ-021 COMPARE with unequal values: load the hold timer and go to HOLD.
REQ-022 HOLD SHALL last exactly HOLD_CYCLES cycles, then clear both pick bits and go to PICK1.
REQ-023 btn_sel SHALL be ignored in COMPARE and HOLD.
REQ-024 Cursor moves SHALL be accepted in PICK1, PICK2, COMPARE and HOLD, and ignored in DONE.
REQ-025 Moves SHALL wrap within the row or column: left from col 0 goes to col 3, down from row 3 goes to row 0.
REQ-026 Simultaneous move pulses: only the highest-priority one applies, in the order up > down > left > right.
REQ-027 btn_sel in the same cycle as a move SHALL act on the pre-move cursor.
REQ-028 game_done SHALL be high exactly while in DONE.
REQ-029 DONE + btn_sel: clear matched, face_up, moves and cursor to 0, and go to PICK1.

Reset
REQ-030 rst_n low SHALL immediately force state PICK1, cursor 0, face_up 0, matched 0, moves 0, game_done 0 and hold timer 0.
REQ-031 Reset asserted mid-HOLD or mid-COMPARE SHALL discard both picks, with no partial update after release.
REQ-032 The first pulse SHALL be honoured on the first clk edge after rst_n deasserts.

Structure
REQ-033 Package memory_pkg SHALL hold NUM_CARDS = 16, GRID_COLS = 4, the FSM state enum and the card-value function.
REQ-034 The hold counter SHALL be a separate sub-module, hold_timer, with load/expire ports, width sized from HOLD_CYCLES.
REQ-035 All other logic SHALL be in a single module.

Verification (bench: HOLD_CYCLES = 4)
REQ-036 Reset, then btn_left once -> cursor = 3; then btn_up -> cursor = 15.
REQ-037 Select 0, move to 8, select -> after COMPARE: matched = 0x0101, face_up = 0x0101, moves = 1.
REQ-038 Select 1, then 2 -> face_up = 0x0006 for 4 cycles after COMPARE, then 0x0000; moves = 1; state PICK1.
REQ-039 Select 5 twice, or select a matched card -> no change to face_up or state.
REQ-040 Match all 8 pairs -> game_done = 1, matched = 0xFFFF, moves = 8; btn_sel -> all outputs 0.
REQ-041 rst_n pulsed low during HOLD -> all outputs 0 asynchronously; the next select starts a fresh PICK1.
